// File: rtl/pack_sequencer.sv
// Write/read control for the 16-lane compaction datapath and its 2x16-word staging ring.
// Optional idle-timeout flush is enabled by defining FLUSH_TIMEOUT_EN.
module pack_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TMO_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_mask,
  input  logic        in_last,
  output logic        wr_en,
  output logic [4:0]  wr_base,
  output logic [4:0]  wr_count,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_bank,
  output logic [4:0]  out_count,
  output logic        out_last
);

  localparam int unsigned PTR_W = 5;
  localparam int unsigned OCC_W = 6;
  localparam int unsigned CNT_W = 5;
  localparam bit          CFG_OK = (64'(1) << TMO_W) > 64'(TIMEOUT_CYCLES);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               rd_bank_q, rd_bank_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               last_seen_q, last_seen_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_last_q, out_last_d;
  logic               fin_q, fin_d;

  logic [7:0][1:0]    pc_l1;
  logic [3:0][2:0]    pc_l2;
  logic [1:0][3:0]    pc_l3;
  logic [CNT_W-1:0]   pc_c;
  logic               accept_c;
  logic               pop_c;
  logic               tmo_fire_c;

  // Popcount adder tree
  always_comb begin
    for (int i = 0; i < 8; i++) pc_l1[i] = 2'(in_mask[2*i]) + 2'(in_mask[2*i+1]);
    for (int i = 0; i < 4; i++) pc_l2[i] = 3'(pc_l1[2*i]) + 3'(pc_l1[2*i+1]);
    for (int i = 0; i < 2; i++) pc_l3[i] = 4'(pc_l2[2*i]) + 4'(pc_l2[2*i+1]);
    pc_c = CNT_W'(pc_l3[0]) + CNT_W'(pc_l3[1]);
  end

  assign in_ready  = (state_q == ST_RUN) && (occ_q <= OCC_W'(16));
  assign accept_c  = in_valid && in_ready;
  assign pop_c     = out_valid_q && out_ready;
  assign wr_en     = accept_c && (pc_c != '0);
  assign wr_base   = wr_ptr_q;
  assign wr_count  = pc_c;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign out_bank  = rd_bank_q;

`ifdef FLUSH_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Idle counter: runs only while a partial bank sits in RUN with no input
  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_fire_c = 1'b0;
    if (accept_c) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ST_RUN) && (occ_q != '0) && (occ_q < OCC_W'(16))) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_fire_c = 1'b1;
        tmo_cnt_d  = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_fire_c = 1'b0;
`endif

  // Next state and registered beat descriptor
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_bank_d   = rd_bank_q;
    occ_d       = occ_q;
    last_seen_d = last_seen_q;
    out_valid_d = 1'b0;
    out_count_d = '0;
    out_last_d  = 1'b0;
    fin_d       = 1'b0;

    if (accept_c) begin
      wr_ptr_d = wr_ptr_q + pc_c;
      occ_d    = occ_q + OCC_W'(pc_c);
      if (in_last) begin
        state_d     = ST_FLUSH;
        last_seen_d = 1'b1;
      end
    end

    if (tmo_fire_c) state_d = ST_FLUSH;

    if (pop_c) begin
      occ_d     = occ_d - OCC_W'(out_count_q);
      rd_bank_d = ~rd_bank_q;
      // Final beat of a flush realigns the ring so the next packet starts in bank 0
      if ((state_q == ST_FLUSH) && fin_q) begin
        state_d     = ST_RUN;
        wr_ptr_d    = '0;
        rd_bank_d   = 1'b0;
        occ_d       = '0;
        last_seen_d = 1'b0;
      end
    end

    out_valid_d = (state_d == ST_FLUSH) || (occ_d >= OCC_W'(16));
    if (out_valid_q && !out_ready) begin
      out_count_d = out_count_q;
      out_last_d  = out_last_q;
      fin_d       = fin_q;
    end else begin
      fin_d       = (state_d == ST_FLUSH) && (occ_d <= OCC_W'(16));
      out_last_d  = fin_d && last_seen_d;
      if (out_valid_d) out_count_d = (occ_d >= OCC_W'(16)) ? CNT_W'(16) : CNT_W'(occ_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_bank_q   <= 1'b0;
      occ_q       <= '0;
      last_seen_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_bank_q   <= rd_bank_d;
      occ_q       <= occ_d;
      last_seen_q <= last_seen_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
      fin_q       <= fin_d;
    end
  end

  // Ring occupancy must track the pointer distance; occ==32 aliases to distance 0
  a_occ_range: assert property (@(posedge clk) disable iff (!rst_n) occ_q <= OCC_W'(32));
  a_occ_ptr: assert property (@(posedge clk) disable iff (!rst_n)
    occ_q[PTR_W-1:0] == PTR_W'(wr_ptr_q - {rd_bank_q, 4'b0000}));
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_count_q)
                                     && $stable(out_last_q) && $stable(rd_bank_q)));
  a_cfg: assert property (@(posedge clk) CFG_OK);

endmodule

// File: tb/tb_pack_sequencer.sv
// Scoreboard bench for pack_sequencer: directed packets, expected beats queued, monitor compares.
module tb_pack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mask;
  logic        in_last;
  logic        wr_en;
  logic [4:0]  wr_base;
  logic [4:0]  wr_count;
  logic        out_valid;
  logic        out_ready;
  logic        out_bank;
  logic [4:0]  out_count;
  logic        out_last;

  typedef struct packed {
    logic [4:0] count;
    logic       bank;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic  stall_v  = 1'b0;
  beat_t held;

  pack_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mask  (in_mask),
    .in_last  (in_last),
    .wr_en    (wr_en),
    .wr_base  (wr_base),
    .wr_count (wr_count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bank (out_bank),
    .out_count(out_count),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_beat(input int count, input int bank, input int last);
    beat_t b;
    b.count = 5'(count);
    b.bank  = 1'(bank);
    b.last  = 1'(last);
    exp_q.push_back(b);
  endtask

  // Output monitor: compares every handshake against the queue and checks stall stability
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v && out_valid) begin
        check("hold_count", int'(out_count), int'(held.count));
        check("hold_bank",  int'(out_bank),  int'(held.bank));
        check("hold_last",  int'(out_last),  int'(held.last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got count %0d bank %0d last %0d, expected no beat",
                   out_count, out_bank, out_last);
        end else begin
          e = exp_q.pop_front();
          check("beat_count", int'(out_count), int'(e.count));
          check("beat_bank",  int'(out_bank),  int'(e.bank));
          check("beat_last",  int'(out_last),  int'(e.last));
        end
      end
      stall_v    = out_valid && !out_ready;
      held.count = out_count;
      held.bank  = out_bank;
      held.last  = out_last;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send_beat(input logic [15:0] m, input logic l, input int exp_base,
                           output int waits);
    in_valid = 1'b1;
    in_mask  = m;
    in_last  = l;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      check("wr_base",  int'(wr_base),  exp_base);
      check("wr_en",    int'(wr_en),    int'(m != 16'h0000));
      check("wr_count", int'(wr_count), $countones(m));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_mask  = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_out_last",  int'(out_last),  0);
    check("rst_out_bank",  int'(out_bank),  0);
    check("rst_wr_en",     int'(wr_en),     0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);

    // Four full beats, last on the fourth
    out_ready = 1'b1;
    push_beat(16, 0, 0);
    push_beat(16, 1, 0);
    push_beat(16, 0, 0);
    push_beat(16, 1, 1);
    send_beat(16'hFFFF, 1'b0, 0,  w);
    send_beat(16'hFFFF, 1'b0, 16, w);
    send_beat(16'hFFFF, 1'b0, 0,  w);
    send_beat(16'hFFFF, 1'b1, 16, w);
    drain(50);

    // Partial packet: 8+8+2 words
    push_beat(16, 0, 0);
    push_beat(2,  1, 1);
    send_beat(16'h00FF, 1'b0, 0,  w);
    send_beat(16'h0F0F, 1'b0, 8,  w);
    send_beat(16'h0003, 1'b1, 16, w);
    drain(50);

    // Backpressure: ring fills after two beats
    out_ready = 1'b0;
    push_beat(16, 0, 0);
    push_beat(16, 1, 0);
    push_beat(16, 0, 1);
    send_beat(16'hFFFF, 1'b0, 0,  w);
    send_beat(16'hFFFF, 1'b0, 16, w);
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready",  int'(in_ready),  0);
      check("full_out_valid", int'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(16'hFFFF, 1'b1, 0, w);
    check("ready_return_wait", w, 1);
    drain(50);

    // Empty packet
    push_beat(0, 0, 1);
    send_beat(16'h0000, 1'b1, 0, w);
    drain(50);
    @(negedge clk);
    check("run_after_empty", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Idle partial bank
`ifdef FLUSH_TIMEOUT_EN
    push_beat(4, 0, 0);
    send_beat(16'h000F, 1'b0, 0, w);
    drain(300);
    push_beat(0, 0, 1);
    send_beat(16'h0000, 1'b1, 0, w);
    drain(50);
`else
    send_beat(16'h000F, 1'b0, 0, w);
    repeat (100) @(posedge clk);
    #1;
    check("idle_no_beat", int'(out_valid), 0);
    push_beat(4, 0, 1);
    send_beat(16'h0000, 1'b1, 4, w);
    drain(50);
`endif

    // Asynchronous reset during a stalled flush
    out_ready = 1'b0;
    send_beat(16'h0003, 1'b1, 0, w);
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("flush_valid", int'(out_valid), 1);
    check("flush_last",  int'(out_last),  1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_last",  int'(out_last),  0);
    check("async_rst_count", int'(out_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_beat(8, 0, 1);
    send_beat(16'h00FF, 1'b1, 0, w);
    drain(50);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
